mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Op  input  6  opcode field of the instruction register.
REQ-005 Zero  input  1  ALU zero flag from the current cycle.
REQ-006 MemReady  input  1  memory handshake; 1 = current memory access completes this cycle.
REQ-007 IorD, ALUSrcA, RegDst, MemtoReg  output  1 each  datapath mux selects.
REQ-008 ALUSrcB  output  2  00=rd2, 01=const 4, 10=SignImm, 11=SignImm<<2.
REQ-009 PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target.
REQ-010 ALUOp  output  2  00=add, 01=subtract, 10=use Funct; consumed by the downstream ALU decoder.
REQ-011 IRWrite, MemWrite, RegWrite, PCEn  output  1 each  write strobes.

Function
REQ-012 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, JUMP, ADDIEXEC, ADDIWB.
REQ-013 Outputs SHALL be a combinational decode of the registered state, plus Zero and MemReady where stated; no output SHALL be registered separately.
REQ-014 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCEn=MemReady.
REQ-015 FETCH SHALL stay in FETCH while MemReady=0; it SHALL go to DECODE when MemReady=1.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-017 DECODE SHALL branch on Op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 000010->JUMP, 001000->ADDIEXEC; any other opcode SHALL return to FETCH with no writes.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw->MEMREAD, sw->MEMWRITE.
REQ-019 MEMREAD: IorD=1; SHALL hold until MemReady=1, then go to MEMWB.
REQ-020 MEMWRITE: IorD=1, MemWrite=1; SHALL hold until MemReady=1, then go to FETCH.
REQ-021 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; then FETCH.
REQ-022 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then ALUWB.
REQ-023 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; then FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=Zero; then FETCH.
REQ-025 JUMP: PCSrc=10, PCEn=1; then FETCH.
REQ-026 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00; then ADDIWB.
REQ-027 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; then FETCH.
REQ-028 Every output not listed for a state SHALL be 0 in that state.
REQ-029 Latency in cycles with MemReady held at 1: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3, illegal opcode=2.
REQ-030 An illegal state encoding SHALL decode to all-zero strobes and SHALL return to FETCH on the next edge.

Reset
REQ-031 rst_n=0 SHALL force the state to FETCH immediately, independent of clk, including mid-instruction.
REQ-032 During reset, outputs SHALL equal the FETCH decode: ALUSrcB=01, all other selects 0, IRWrite=PCEn=MemReady, MemWrite=RegWrite=0.
REQ-033 The first state advance SHALL occur on the first rising clk edge after rst_n deasserts.

Configuration
REQ-034 Macro MC_CTRL_ADDI_EN: when defined, ADDIEXEC and ADDIWB exist and Op=001000 is legal.
REQ-035 When MC_CTRL_ADDI_EN is undefined, both addi states SHALL be absent and Op=001000 SHALL be treated as an illegal opcode.

Structure
REQ-036 Package mc_ctrl_pkg SHALL hold the state enum, the opcode constants, and the ALUOp, ALUSrcB and PCSrc encodings.
REQ-037 The state-to-output decode SHALL live in sub-module mc_ctrl_outdec; the state register and next-state logic SHALL live in mc_control_fsm.

Verification
REQ-038 Reset, then Op=100011 with MemReady=1: states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-039 Op=000000: ALUOp=10 in cycle 3; RegWrite=1 and RegDst=1 in cycle 4; back in FETCH at cycle 5.
REQ-040 Op=000100: Zero=1 gives PCEn=1, PCSrc=01, ALUOp=01 in cycle 3; Zero=0 gives PCEn=0 in cycle 3.
REQ-041 MemReady=0 for 2 cycles in FETCH: state held, IRWrite=0 and PCEn=0; IRWrite=1 on the 3rd cycle.
REQ-042 rst_n pulsed low during MEMWRITE: MemWrite drops to 0 immediately and the state is FETCH.
REQ-043 Op=001000 with MC_CTRL_ADDI_EN undefined: DECODE->FETCH with no RegWrite; with the macro defined, RegWrite=1 in cycle 4.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state enum, opcodes, mux selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: MC_CTRL_ADDI_EN adds the ADDIEXEC/ADDIWB states.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
`ifdef MC_CTRL_ADDI_EN
        JUMP     = 4'd9,
        ADDIEXEC = 4'd10,
        ADDIWB   = 4'd11
`else
        JUMP     = 4'd9
`endif
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Purely combinational state-to-control decode for the multicycle datapath.
// Latency: 0 cycles (outputs follow state, Zero and MemReady in the same cycle).
// Backpressure: MemReady gates the fetch strobes; unknown/illegal states drive all zeros.
// Ports: state in; Zero, MemReady in; mux selects and write strobes out.
// Optional feature macro: MC_CTRL_ADDI_EN decodes ADDIEXEC/ADDIWB.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCEn
);

    always_comb begin
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcB  = SRCB_RD2;
        PCSrc    = PCSRC_ALU;
        ALUOp    = ALUOP_ADD;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        PCEn     = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB = SRCB_FOUR;
                // IR load and PC+4 commit only once the instruction word has arrived.
                IRWrite = MemReady;
                PCEn    = MemReady;
            end
            DECODE: begin
                // Precompute the branch target while the opcode is being decoded.
                ALUSrcB = SRCB_IMMSH2;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                IorD = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                PCEn    = Zero;
            end
            JUMP: begin
                PCSrc = PCSRC_JUMP;
                PCEn  = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style main controller: state register, next-state logic, output decode.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3, illegal opcode 2 cycles (MemReady held high).
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until MemReady=1.
// Ports: clk, rst_n (async active-low); Op, Zero, MemReady in; datapath selects/strobes out.
// Optional feature macro: MC_CTRL_ADDI_EN makes Op=001000 legal (ADDIEXEC/ADDIWB).
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCEn
);

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      next_state = ADDIEXEC;
`endif
                    // Unknown opcodes abandon the instruction without any write.
                    default:      next_state = FETCH;
                endcase
            end
            // Only lw/sw can reach MEMADR, so anything other than sw is a load.
            MEMADR:   next_state = (Op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = MemReady ? MEMWB : MEMREAD;
            MEMWRITE: next_state = MemReady ? FETCH : MEMWRITE;
            MEMWB:    next_state = FETCH;
            EXECUTE:  next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BRANCH:   next_state = FETCH;
            JUMP:     next_state = FETCH;
`ifdef MC_CTRL_ADDI_EN
            ADDIEXEC: next_state = ADDIWB;
            ADDIWB:   next_state = FETCH;
`endif
            // Illegal encodings recover to FETCH on the next edge.
            default:  next_state = FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state    (state),
        .Zero     (Zero),
        .MemReady (MemReady),
        .IorD     (IorD),
        .ALUSrcA  (ALUSrcA),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .ALUSrcB  (ALUSrcB),
        .PCSrc    (PCSrc),
        .ALUOp    (ALUOp),
        .IRWrite  (IRWrite),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .PCEn     (PCEn)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm; expected values are hand-computed per state.
// Latency: n/a.
// Backpressure: exercises MemReady stalls in FETCH and MEMWRITE.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       IorD, ALUSrcA, RegDst, MemtoReg;
    logic [1:0] ALUSrcB, PCSrc, ALUOp;
    logic       IRWrite, MemWrite, RegWrite, PCEn;

    int n_checks = 0;
    int n_fails  = 0;

    mc_control_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Op       (Op),
        .Zero     (Zero),
        .MemReady (MemReady),
        .IorD     (IorD),
        .ALUSrcA  (ALUSrcA),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .ALUSrcB  (ALUSrcB),
        .PCSrc    (PCSrc),
        .ALUOp    (ALUOp),
        .IRWrite  (IRWrite),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .PCEn     (PCEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        check(tag, 32'(dut.state), 32'(exp));
    endtask

    initial begin
        rst_n    = 1'b0;
        Op       = OP_LW;
        Zero     = 1'b0;
        MemReady = 1'b0;

        // Reset state with MemReady low, then high (fetch strobes follow MemReady).
        #12;
        chk_state("rst_state", FETCH);
        check("rst_srcb", 32'(ALUSrcB), 32'(SRCB_FOUR));
        check("rst_irwrite0", 32'(IRWrite), 0);
        check("rst_pcen0", 32'(PCEn), 0);
        check("rst_memwrite", 32'(MemWrite), 0);
        check("rst_regwrite", 32'(RegWrite), 0);
        check("rst_sels", 32'({IorD, ALUSrcA, RegDst, MemtoReg, PCSrc, ALUOp}), 0);
        MemReady = 1'b1;
        #1;
        check("rst_irwrite1", 32'(IRWrite), 1);
        check("rst_pcen1", 32'(PCEn), 1);
        step();                       // clock edge while reset held
        chk_state("rst_hold", FETCH);
        #4 rst_n = 1'b1;              // release between edges
        #1;
        chk_state("lw_c1", FETCH);

        // lw: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH
        step();
        chk_state("lw_c2", DECODE);
        check("lw_c2_srcb", 32'(ALUSrcB), 32'(SRCB_IMMSH2));
        check("lw_c2_regwrite", 32'(RegWrite), 0);
        step();
        chk_state("lw_c3", MEMADR);
        check("lw_c3_srca", 32'(ALUSrcA), 1);
        check("lw_c3_srcb", 32'(ALUSrcB), 32'(SRCB_IMM));
        step();
        chk_state("lw_c4", MEMREAD);
        check("lw_c4_iord", 32'(IorD), 1);
        check("lw_c4_regwrite", 32'(RegWrite), 0);
        step();
        chk_state("lw_c5", MEMWB);
        check("lw_c5_regwrite", 32'(RegWrite), 1);
        check("lw_c5_memtoreg", 32'(MemtoReg), 1);
        check("lw_c5_regdst", 32'(RegDst), 0);
        step();
        chk_state("lw_c6", FETCH);
        check("lw_c6_regwrite", 32'(RegWrite), 0);
        check("lw_c6_memtoreg", 32'(MemtoReg), 0);

        // R-type
        Op = OP_RTYPE;
        step();
        chk_state("r_c2", DECODE);
        step();
        chk_state("r_c3", EXECUTE);
        check("r_c3_aluop", 32'(ALUOp), 32'(ALUOP_FUNCT));
        check("r_c3_srcb", 32'(ALUSrcB), 32'(SRCB_RD2));
        check("r_c3_srca", 32'(ALUSrcA), 1);
        step();
        chk_state("r_c4", ALUWB);
        check("r_c4_regwrite", 32'(RegWrite), 1);
        check("r_c4_regdst", 32'(RegDst), 1);
        step();
        chk_state("r_c5", FETCH);

        // beq, Zero toggled while in BRANCH
        Op = OP_BEQ;
        step();
        chk_state("beq_c2", DECODE);
        Zero = 1'b1;
        step();
        chk_state("beq_c3", BRANCH);
        check("beq_pcen_z1", 32'(PCEn), 1);
        check("beq_pcsrc", 32'(PCSrc), 32'(PCSRC_ALUOUT));
        check("beq_aluop", 32'(ALUOp), 32'(ALUOP_SUB));
        Zero = 1'b0;
        #1;
        check("beq_pcen_z0", 32'(PCEn), 0);
        step();
        chk_state("beq_c4", FETCH);

        // j
        Op = OP_J;
        step();
        step();
        chk_state("j_c3", JUMP);
        check("j_pcsrc", 32'(PCSrc), 32'(PCSRC_JUMP));
        check("j_pcen", 32'(PCEn), 1);
        step();
        chk_state("j_c4", FETCH);

        // MemReady stall in FETCH, then an illegal opcode
        Op = 6'b111111;
        MemReady = 1'b0;
        #1;
        check("stall_irwrite_a", 32'(IRWrite), 0);
        check("stall_pcen_a", 32'(PCEn), 0);
        step();
        chk_state("stall_hold1", FETCH);
        check("stall_irwrite_b", 32'(IRWrite), 0);
        step();
        chk_state("stall_hold2", FETCH);
        check("stall_pcen_b", 32'(PCEn), 0);
        MemReady = 1'b1;
        #1;
        check("stall_irwrite_c", 32'(IRWrite), 1);
        step();
        chk_state("ill_c2", DECODE);
        step();
        chk_state("ill_c3", FETCH);
        check("ill_regwrite", 32'(RegWrite), 0);

        // addi
        Op = OP_ADDI;
        step();
        chk_state("addi_c2", DECODE);
        step();
`ifdef MC_CTRL_ADDI_EN
        chk_state("addi_c3", ADDIEXEC);
        check("addi_c3_srcb", 32'(ALUSrcB), 32'(SRCB_IMM));
        check("addi_c3_srca", 32'(ALUSrcA), 1);
        step();
        chk_state("addi_c4", ADDIWB);
        check("addi_c4_regwrite", 32'(RegWrite), 1);
        check("addi_c4_regdst", 32'(RegDst), 0);
        step();
        chk_state("addi_c5", FETCH);
`else
        chk_state("addi_c3", FETCH);
        check("addi_c3_regwrite", 32'(RegWrite), 0);
`endif

        // sw held in MEMWRITE, reset pulsed between clock edges
        Op = OP_SW;
        step();
        chk_state("sw_c2", DECODE);
        step();
        chk_state("sw_c3", MEMADR);
        MemReady = 1'b0;
        step();
        chk_state("sw_c4", MEMWRITE);
        check("sw_memwrite", 32'(MemWrite), 1);
        check("sw_iord", 32'(IorD), 1);
        step();
        chk_state("sw_hold", MEMWRITE);
        #2 rst_n = 1'b0;
        #1;
        check("arst_memwrite", 32'(MemWrite), 0);
        chk_state("arst_state", FETCH);
        check("arst_srcb", 32'(ALUSrcB), 32'(SRCB_FOUR));
        check("arst_iord", 32'(IorD), 0);
        #1 rst_n = 1'b1;
        MemReady = 1'b1;
        #1;
        chk_state("arst_post", FETCH);
        step();
        chk_state("arst_adv", DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
